led_chase_monitor: RTL and testbench
====================================

Name: led_chase_monitor

Overview:
Observes the 8-bit LED bus driven by a running-LED (chaser) mode generator and decodes it: locks onto a one-hot running pattern, reports direction and current position, and flags pattern errors and stalls. Sits on the consumer side of the mode generators in the COMBINE4MODE design. It is the self-check/readback block used in simulation and for on-board status.

Parameters:
STALL_MAX, 8, consecutive enabled cycles with an unchanged pattern before stall asserts (range 2..255)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  sample enable; 0 = freeze all state
led_in  input  8  LED bus from the chaser generator
locked  output  1  1 = valid running sequence tracked
dir  output  1  0 = left-to-right (bit7 toward bit0), 1 = right-to-left (bit0 toward bit7)
pos  output  3  index of lit bit in last accepted pattern
stall  output  1  pattern unchanged for >= STALL_MAX enabled cycles while ACQUIRE/LOCKED
err_pulse  output  1  one-cycle pulse per detected error
err_count  output  8  errors since reset, saturates at 255

Behaviour:
- Single clock; reset synchronous and active-high, wins over en. Reset: state=IDLE, prev=0, locked=0, dir=0, pos=0, stall=0, err_pulse=0, err_count=0, hold counter=0.
- All outputs registered; led_in sampled at edge k (en=1) is reflected in outputs after edge k (latency 1 clock).
- en=0: no sampling, state, prev, counters and outputs hold; err_pulse forced 0.
- Definitions: one-hot = exactly one bit set. L2R next of p = rotate right (0x01 -> 0x80 wrap). R2L next of p = rotate left (0x80 -> 0x01 wrap).
- States: IDLE, ACQUIRE, LOCKED.
- IDLE: sample 0x00 -> stay, no error. One-hot -> ACQUIRE, prev=sample, pos=index. Other -> error, stay IDLE.
- ACQUIRE: sample==prev -> hold. L2R next -> LOCKED, dir=0. R2L next -> LOCKED, dir=1. Otherwise -> error. On transition to LOCKED: locked=1, prev/pos updated.
- LOCKED: sample==prev -> hold. Sample==next(prev, dir) -> prev/pos updated. Otherwise -> error, locked=0.
- Error event: err_pulse=1 for exactly one cycle, err_count+1 (saturate at 255). Resync: if the offending sample is one-hot, go to ACQUIRE with prev=sample. Otherwise go to IDLE with prev=0.
- Hold counter (8-bit, saturating): increments on each enabled sample==prev in ACQUIRE/LOCKED. Clears on any accepted change, error, or IDLE. stall=1 when counter >= STALL_MAX-1, i.e. the STALL_MAX-th consecutive identical sample, counting the first acceptance. Stall is not an error and does not clear locked.
- Direction reversal while LOCKED (e.g. 0x20 -> 0x40 in L2R) is an error and resyncs via ACQUIRE.
- Reset mid-operation: all state back to reset values on that edge. The next sample is treated as from IDLE.

Test Plan:
1. Reset, en=1, led_in 0x80,0x40,0x20 one cycle each -> locked=1, dir=0 after the 0x40 edge. pos=5 after the 0x20 edge. err_count=0.
2. L2R wrap: locked on ...0x02,0x01,0x80,0x40 -> no err_pulse, pos=7 after 0x80, locked stays 1.
3. R2L: 0x01,0x02,0x04,0x08 -> locked=1, dir=1, pos=3. Then 0x80->0x01 wrap case likewise passes.
4. Glitch: locked L2R at 0x10, drive 0x24 -> err_pulse one cycle, err_count=1, locked=0, state IDLE. Then 0x08,0x04 -> relocked dir=0. Next, inject reversal 0x08 after 0x04 -> err_count=2, ACQUIRE with prev=0x08.
5. Stall (STALL_MAX=4): locked, hold 0x10 for 4 enabled cycles total -> stall=1 from the 4th sample edge. Drive 0x08 -> stall=0, locked=1. Drop en for 10 cycles mid-hold -> no counter change. Drive 300 bad patterns -> err_count=255.
6. Reset mid-run while locked with err_count=3 -> next cycle all outputs 0. Sample 0x40 -> ACQUIRE, pos=6, locked=0.

Source files
------------

// File: rtl/led_chase_if.sv
// LED chaser observation bus: sample enable and LED pattern in, decoded status out.
// The monitor attaches through the slave modport; the stimulus side uses master.
interface led_chase_if;
    logic       en;
    logic [7:0] led_in;
    logic       locked;
    logic       dir;
    logic [2:0] pos;
    logic       stall;
    logic       err_pulse;
    logic [7:0] err_count;

    modport master (
        output en,
        output led_in,
        input  locked,
        input  dir,
        input  pos,
        input  stall,
        input  err_pulse,
        input  err_count
    );

    modport slave (
        input  en,
        input  led_in,
        output locked,
        output dir,
        output pos,
        output stall,
        output err_pulse,
        output err_count
    );
endinterface

// File: rtl/led_chase_monitor.sv
// Decodes a running-LED bus: locks onto a one-hot chase, reports direction and
// position, counts pattern errors and flags a stalled pattern.
module led_chase_monitor #(
    parameter int unsigned STALL_MAX = 8
) (
    input logic        clk,
    input logic        reset,
    led_chase_if.slave bus
);

    localparam int unsigned LED_W = 8;
    localparam int unsigned POS_W = 3;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] HOLD_THR = CNT_W'(STALL_MAX - 1);

    generate
        if (STALL_MAX < 2 || STALL_MAX > 255) begin : g_bad_stall_max
            $error("led_chase_monitor: STALL_MAX must be in 2..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [LED_W-1:0]   prev;
    logic [LED_W-1:0]   prev_next;
    logic [POS_W-1:0]   pos;
    logic [POS_W-1:0]   pos_next;
    logic               dir;
    logic               dir_next;
    logic               locked;
    logic               locked_next;
    logic               stall;
    logic               stall_next;
    logic               err_pulse;
    logic               err_next;
    logic [CNT_W-1:0]   err_count;
    logic [CNT_W-1:0]   err_count_next;
    logic [CNT_W-1:0]   hold;
    logic [CNT_W-1:0]   hold_next;

    logic               sample_one_hot;
    logic [POS_W-1:0]   sample_idx;
    logic               sample_same;
    logic [LED_W-1:0]   rot_r;
    logic [LED_W-1:0]   rot_l;
    logic [LED_W-1:0]   chase_next;
    logic [CNT_W-1:0]   hold_inc;
    logic [CNT_W-1:0]   err_inc;

    // Sample classification and the two candidate successors of prev.
    always_comb begin
        sample_one_hot = (bus.led_in != '0) &&
                         ((bus.led_in & (bus.led_in - LED_W'(1))) == '0);
        sample_idx = '0;
        for (int i = 0; i < int'(LED_W); i++) begin
            if (bus.led_in[i]) sample_idx = POS_W'(i);
        end
        sample_same = (bus.led_in == prev);
        rot_r       = {prev[0], prev[LED_W-1:1]};
        rot_l       = {prev[LED_W-2:0], prev[LED_W-1]};
        chase_next  = dir ? rot_l : rot_r;
        hold_inc    = (hold == CNT_MAX) ? hold : hold + CNT_W'(1);
        err_inc     = (err_count == CNT_MAX) ? err_count : err_count + CNT_W'(1);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next     = state;
        prev_next      = prev;
        pos_next       = pos;
        dir_next       = dir;
        locked_next    = locked;
        hold_next      = hold;
        err_next       = 1'b0;
        err_count_next = err_count;
        stall_next     = stall;

        if (bus.en) begin
            case (state)
                IDLE: begin
                    hold_next = '0;
                    if (sample_one_hot) begin
                        state_next = ACQUIRE;
                        prev_next  = bus.led_in;
                        pos_next   = sample_idx;
                    end else if (bus.led_in != '0) begin
                        err_next = 1'b1;
                    end
                end

                ACQUIRE: begin
                    if (sample_same) begin
                        hold_next = hold_inc;
                    end else if (bus.led_in == rot_r || bus.led_in == rot_l) begin
                        state_next  = LOCKED;
                        locked_next = 1'b1;
                        dir_next    = (bus.led_in == rot_l);
                        prev_next   = bus.led_in;
                        pos_next    = sample_idx;
                        hold_next   = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end

                LOCKED: begin
                    if (sample_same) begin
                        hold_next = hold_inc;
                    end else if (bus.led_in == chase_next) begin
                        prev_next = bus.led_in;
                        pos_next  = sample_idx;
                        hold_next = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end

                default: begin
                    state_next  = IDLE;
                    prev_next   = '0;
                    locked_next = 1'b0;
                    hold_next   = '0;
                end
            endcase

            // Any error resyncs: a one-hot offender becomes the new anchor.
            if (err_next) begin
                err_count_next = err_inc;
                locked_next    = 1'b0;
                hold_next      = '0;
                if (sample_one_hot) begin
                    state_next = ACQUIRE;
                    prev_next  = bus.led_in;
                    pos_next   = sample_idx;
                end else begin
                    state_next = IDLE;
                    prev_next  = '0;
                end
            end

            stall_next = (state_next != IDLE) && (hold_next >= HOLD_THR);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prev      <= '0;
            pos       <= '0;
            dir       <= 1'b0;
            locked    <= 1'b0;
            hold      <= '0;
            stall     <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            prev      <= prev_next;
            pos       <= pos_next;
            dir       <= dir_next;
            locked    <= locked_next;
            hold      <= hold_next;
            stall     <= stall_next;
            err_pulse <= err_next;
            err_count <= err_count_next;
        end
    end

    assign bus.locked    = locked;
    assign bus.dir       = dir;
    assign bus.pos       = pos;
    assign bus.stall     = stall;
    assign bus.err_pulse = err_pulse;
    assign bus.err_count = err_count;

endmodule

// File: tb/tb_led_chase_monitor.sv
// Scoreboard bench for led_chase_monitor: directed chase scenarios plus random
// traffic, checked against an index-arithmetic reference model.
module tb_led_chase_monitor;

    localparam int unsigned STALL_MAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    led_chase_if bus ();

    led_chase_monitor #(.STALL_MAX(STALL_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       locked;
        logic       dir;
        logic [2:0] pos;
        logic       stall;
        logic       err_pulse;
        logic [7:0] err_count;
    } exp_t;

    exp_t expq[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: "anchored" means a one-hot reference pattern is held.
    bit         m_anchored;
    bit         m_locked;
    bit         m_dir;
    int         m_pos;
    logic [7:0] m_prev;
    int         m_hold;
    int         m_errs;
    bit         m_stall;
    bit         m_pulse;

    function automatic bit is_one_hot(input logic [7:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic int index_of(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [7:0] led_at(input int idx);
        logic [7:0] v;
        v = 8'd1 << (idx % 8);
        return v;
    endfunction

    task automatic model_error(input logic [7:0] s);
        m_pulse  = 1'b1;
        m_errs   = (m_errs < 255) ? m_errs + 1 : 255;
        m_locked = 1'b0;
        m_hold   = 0;
        if (is_one_hot(s)) begin
            m_anchored = 1'b1;
            m_prev     = s;
            m_pos      = index_of(s);
        end else begin
            m_anchored = 1'b0;
            m_prev     = 8'h00;
        end
    endtask

    task automatic model_step(input logic rst, input logic e, input logic [7:0] s);
        int l2r_idx;
        int r2l_idx;
        m_pulse = 1'b0;
        if (rst) begin
            m_anchored = 1'b0; m_locked = 1'b0; m_dir = 1'b0; m_pos = 0;
            m_prev = 8'h00; m_hold = 0; m_errs = 0; m_stall = 1'b0;
            return;
        end
        if (!e) return;
        l2r_idx = (m_pos + 7) % 8;
        r2l_idx = (m_pos + 1) % 8;
        if (!m_anchored) begin
            m_hold = 0;
            if (is_one_hot(s)) begin
                m_anchored = 1'b1; m_prev = s; m_pos = index_of(s);
            end else if (s != 8'h00) begin
                model_error(s);
            end
        end else if (s == m_prev) begin
            m_hold = (m_hold < 255) ? m_hold + 1 : 255;
        end else if (!m_locked) begin
            if (s == led_at(l2r_idx) || s == led_at(r2l_idx)) begin
                m_locked = 1'b1;
                m_dir    = (s == led_at(r2l_idx));
                m_prev   = s; m_pos = index_of(s); m_hold = 0;
            end else begin
                model_error(s);
            end
        end else begin
            if (s == led_at(m_dir ? r2l_idx : l2r_idx)) begin
                m_prev = s; m_pos = index_of(s); m_hold = 0;
            end else begin
                model_error(s);
            end
        end
        m_stall = m_anchored && (m_hold >= int'(STALL_MAX) - 1);
    endtask

    // Apply one cycle of stimulus; the expectation is queued at the sampling edge.
    task automatic drive(input logic rst, input logic e, input logic [7:0] s);
        exp_t x;
        reset      = rst;
        bus.en     = e;
        bus.led_in = s;
        @(posedge clk);
        model_step(rst, e, s);
        x.locked    = m_locked;
        x.dir       = m_dir;
        x.pos       = 3'(m_pos);
        x.stall     = m_stall;
        x.err_pulse = m_pulse;
        x.err_count = 8'(m_errs);
        expq.push_back(x);
        #1;
    endtask

    task automatic seq(input logic [7:0] pats[]);
        foreach (pats[i]) drive(1'b0, 1'b1, pats[i]);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: every registered output update is popped and compared.
    always @(negedge clk) begin
        exp_t x;
        if (expq.size() > 0) begin
            x = expq.pop_front();
            chk("locked",    int'(bus.locked),    int'(x.locked));
            chk("dir",       int'(bus.dir),       int'(x.dir));
            chk("pos",       int'(bus.pos),       int'(x.pos));
            chk("stall",     int'(bus.stall),     int'(x.stall));
            chk("err_pulse", int'(bus.err_pulse), int'(x.err_pulse));
            chk("err_count", int'(bus.err_count), int'(x.err_count));
        end
    end

    initial begin
        int         r;
        int         nidx;
        logic [7:0] s;

        reset = 1'b1; bus.en = 1'b1; bus.led_in = 8'h00;

        // Lock L2R, then run through the 0x01 -> 0x80 wrap.
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h00);
        seq('{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80, 8'h40});

        // R2L with the 0x80 -> 0x01 wrap.
        drive(1'b1, 1'b1, 8'h00);
        seq('{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02});

        // Glitch, relock, then a direction reversal.
        drive(1'b1, 1'b1, 8'h00);
        seq('{8'h80, 8'h40, 8'h20, 8'h10, 8'h24, 8'h08, 8'h04, 8'h08, 8'h04, 8'h00});

        // Stall, release, frozen hold with en low, then error saturation.
        drive(1'b1, 1'b1, 8'h00);
        seq('{8'h20, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h08, 8'h08});
        repeat (10) drive(1'b0, 1'b0, 8'($urandom));
        seq('{8'h08, 8'h08, 8'h04});
        repeat (300) drive(1'b0, 1'b1, 8'hFF);

        // Reset while locked with errors recorded, then restart from IDLE.
        drive(1'b1, 1'b1, 8'h00);
        seq('{8'h80, 8'h40, 8'hFF, 8'h81, 8'h03, 8'h80, 8'h40});
        drive(1'b1, 1'b1, 8'h40);
        seq('{8'h40, 8'h20});

        // Random traffic biased toward valid chase steps.
        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                drive(1'b1, 1'b1, 8'($urandom));
            end else if (r < 10) begin
                drive(1'b0, 1'b0, 8'($urandom));
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 50 && m_anchored) begin
                    if (m_locked) nidx = m_dir ? m_pos + 1 : m_pos + 7;
                    else          nidx = ($urandom_range(0, 1) == 0) ? m_pos + 1 : m_pos + 7;
                    s = led_at(nidx);
                end else if (r < 70) begin
                    s = bus.led_in;
                end else if (r < 82) begin
                    s = led_at(int'($urandom_range(0, 7)));
                end else if (r < 90) begin
                    s = 8'h00;
                end else begin
                    s = 8'($urandom);
                end
                drive(1'b0, 1'b1, s);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        if (expq.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
